// File: rtl/csi2_pkg.sv
// Shared types and constants for the CSI-2 virtual-channel packet path.
// Used by the packet arbiter and the round-robin picker.
package csi2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        GAP,
        FLUSH
    } arb_state_t;

    localparam int CSI2_MAX_PKT_BYTES = 4102;
    localparam int CSI2_DEFAULT_GAP   = 2;

endpackage

// File: rtl/csi2_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward
// from the slot after last_grant, wrapping modulo N.
module csi2_rr_pick
    import csi2_pkg::*;
#(
    parameter int N    = 4,
    parameter int VC_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [VC_W-1:0] last_grant,
    output logic            any,
    output logic [VC_W-1:0] pick
);

    int   idx;
    logic found;

    always_comb begin
        any   = |req;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_grant) + k) % N;
            if (!found && req[idx]) begin
                pick  = VC_W'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/csi2_vc_packet_arbiter.sv
// Packet-granular round-robin arbiter feeding the CSI-2 packet stripper.
// Optional watchdog truncation is enabled with `define CSI2_ARB_WATCHDOG_EN.
module csi2_vc_packet_arbiter
    import csi2_pkg::*;
#(
    parameter int N          = 4,
    parameter int VC_W       = 2,
    parameter int GAP_CYCLES = CSI2_DEFAULT_GAP,
    parameter int MAX_BYTES  = CSI2_MAX_PKT_BYTES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req_valid,
    input  logic [N*8-1:0]  req_data,
    input  logic [N-1:0]    req_last,
    output logic [N-1:0]    req_ready,
    output logic            out_valid,
    output logic [7:0]      out_data,
    output logic            out_sop,
    output logic            out_eop,
    output logic [VC_W-1:0] out_vc,
    input  logic            out_ready,
    output logic            busy,
    output logic            timeout
);

    localparam logic [15:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
    localparam arb_state_t AFTER_PKT =
        (GAP_CYCLES > 0) ? GAP : IDLE;
`ifdef CSI2_ARB_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(MAX_BYTES - 1);
`endif

    arb_state_t      state, state_n;
    logic [VC_W-1:0] grant, grant_n;
    logic [VC_W-1:0] last_grant, last_grant_n;
    logic            first_beat, first_beat_n;
    logic [15:0]     byte_cnt, byte_cnt_n;
    logic [15:0]     gap_cnt, gap_cnt_n;
    logic            any;
    logic [VC_W-1:0] pick;
    logic            beat;
    logic            wd_hit;
    logic [7:0]      lane [N];

    csi2_rr_pick #(
        .N    (N),
        .VC_W (VC_W)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .any        (any),
        .pick       (pick)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            lane[i] = req_data[i*8 +: 8];
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= VC_W'(N - 1);
            first_beat <= 1'b1;
            byte_cnt   <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_grant <= last_grant_n;
            first_beat <= first_beat_n;
            byte_cnt   <= byte_cnt_n;
            gap_cnt    <= gap_cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        last_grant_n = last_grant;
        first_beat_n = first_beat;
        byte_cnt_n   = byte_cnt;
        gap_cnt_n    = gap_cnt;
        out_valid    = 1'b0;
        out_data     = 8'd0;
        out_sop      = 1'b0;
        out_eop      = 1'b0;
        out_vc       = '0;
        req_ready    = '0;
        timeout      = 1'b0;
        beat         = 1'b0;
        wd_hit       = 1'b0;
        unique case (state)
            IDLE: begin
                if (any) begin
                    grant_n = pick;
                    state_n = XFER;
                end
            end
            XFER: begin
                out_valid        = req_valid[grant];
                out_vc           = grant;
                out_data         = out_valid ? lane[grant] : 8'd0;
                out_sop          = first_beat & out_valid;
                out_eop          = out_valid & req_last[grant];
                req_ready[grant] = out_ready;
                beat             = out_valid & out_ready;
`ifdef CSI2_ARB_WATCHDOG_EN
                wd_hit = beat & ~req_last[grant] & (byte_cnt == WD_LAST);
                if (wd_hit) begin
                    out_eop = 1'b1;
                    timeout = 1'b1;
                end
`endif
                if (beat) begin
                    first_beat_n = 1'b0;
                    byte_cnt_n   = (&byte_cnt) ? byte_cnt : byte_cnt + 16'd1;
                end
                // A truncated packet still rotates priority like a normal end.
                if (beat && (req_last[grant] || wd_hit)) begin
                    last_grant_n = grant;
                    byte_cnt_n   = '0;
                    first_beat_n = 1'b1;
                    gap_cnt_n    = GAP_LOAD;
                    state_n      = wd_hit ? FLUSH : AFTER_PKT;
                end
            end
            GAP: begin
                if (gap_cnt == 16'd0) begin
                    state_n = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt - 16'd1;
                end
            end
`ifdef CSI2_ARB_WATCHDOG_EN
            FLUSH: begin
                req_ready[grant] = 1'b1;
                if (req_valid[grant] && req_last[grant]) begin
                    gap_cnt_n = GAP_LOAD;
                    state_n   = AFTER_PKT;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_csi2_vc_packet_arbiter.sv
// Directed bench for csi2_vc_packet_arbiter: vector table plus
// hand-written packet streams, watchdog and mid-packet reset sequences.
module tb_csi2_vc_packet_arbiter;

    localparam int N = 4;
`ifdef CSI2_ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] rv;
        logic [3:0] rl;
        logic       ordy;
        logic       ev;
        logic [1:0] evc;
        logic       es;
        logic       ee;
        logic [3:0] erdy;
        logic       eb;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [7:0]     out_data;
    logic           out_sop;
    logic           out_eop;
    logic [1:0]     out_vc;
    logic           out_ready;
    logic           busy;
    logic           timeout;

    int passes = 0;
    int total  = 0;
    int vc_order[$];
    int gap_q[$];
    int idle_q[$];
    int bad;
    int bubs;

    always #5 clk = ~clk;

    csi2_vc_packet_arbiter #(
        .N          (N),
        .VC_W       (2),
        .GAP_CYCLES (2),
        .MAX_BYTES  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_vc    (out_vc),
        .out_ready (out_ready),
        .busy      (busy),
        .timeout   (timeout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] pkt_byte(input int ln, input int ix);
        case (ix)
            0:       return 8'h2A;
            1:       return 8'h04;
            2:       return 8'h00;
            3:       return 8'h30 + 8'(ln);
            4:       return 8'hD0 + 8'(ln);
            default: return 8'hE0 + 8'(ln);
        endcase
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Continuous 6-byte packet sources on the lanes in mask.
    task automatic run_stream(input logic [N-1:0] mask, input bit toggle,
                              input int bub_lane, input int npk);
        int idx[N];
        int cur, pk, cyc, gapc, idlec, bub_left, l;
        bit in_pkt, have_prev;
        for (int i = 0; i < N; i++) idx[i] = 0;
        cur = 0; pk = 0; cyc = 0; gapc = 0; idlec = 0; bub_left = 3;
        in_pkt = 0; have_prev = 0; bad = 0; bubs = 0;
        vc_order.delete(); gap_q.delete(); idle_q.delete();
        while (pk < npk && cyc < 300) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                req_valid[i]      = mask[i];
                req_data[i*8 +: 8] = pkt_byte(i, idx[i]);
                req_last[i]       = (idx[i] == 5);
            end
            if (bub_lane >= 0 && idx[bub_lane] == 2 && bub_left > 0) begin
                req_valid[bub_lane] = 1'b0;
                bub_left--;
            end
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (out_valid) begin
                l = int'(out_vc);
                if (in_pkt && l != cur) bad++;
                if (out_data !== pkt_byte(l, idx[l])) bad++;
                if (out_sop !== (idx[l] == 0)) bad++;
                if (out_eop !== (idx[l] == 5)) bad++;
                if (req_ready !== (out_ready ? (N'(1) << l) : '0)) bad++;
                if (out_ready) begin
                    if (out_sop) begin
                        in_pkt = 1; cur = l;
                        if (have_prev) begin
                            gap_q.push_back(gapc);
                            idle_q.push_back(idlec);
                        end
                    end
                    if (out_eop) begin
                        vc_order.push_back(l);
                        pk++; in_pkt = 0; have_prev = 1;
                        gapc = 0; idlec = 0;
                    end
                end
            end else begin
                if (in_pkt) begin
                    if (busy) bubs++;
                    else bad++;
                end else if (have_prev) begin
                    if (busy) gapc++;
                    else idlec++;
                end
                if (!busy && req_ready !== '0) bad++;
            end
            for (int i = 0; i < N; i++)
                if (req_valid[i] && req_ready[i]) idx[i] = (idx[i] + 1) % 6;
            cyc++;
        end
        chk("stream_done", 64'(pk), 64'(npk));
    endtask

    function automatic int ord(input int i);
        return (i < vc_order.size()) ? vc_order[i] : -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[17];
        int   exp2[4];
        int   exp3[5];
        logic [7:0] expd;
        int   k, vis, eop_at, to_cnt, to_at, i1, lat, lvc, lsop;
        bit   done, hit;

        vecs[0]  = '{4'b0000, 4'b0000, 1, 0, 2'd0, 0, 0, 4'b0000, 0};
        vecs[1]  = '{4'b0001, 4'b0000, 1, 0, 2'd0, 0, 0, 4'b0000, 0};
        vecs[2]  = '{4'b0101, 4'b0000, 1, 1, 2'd0, 1, 0, 4'b0001, 1};
        vecs[3]  = '{4'b0101, 4'b0001, 0, 1, 2'd0, 0, 1, 4'b0000, 1};
        vecs[4]  = '{4'b0101, 4'b0001, 1, 1, 2'd0, 0, 1, 4'b0001, 1};
        vecs[5]  = '{4'b0101, 4'b0000, 1, 0, 2'd0, 0, 0, 4'b0000, 1};
        vecs[6]  = '{4'b0101, 4'b0000, 1, 0, 2'd0, 0, 0, 4'b0000, 1};
        vecs[7]  = '{4'b0101, 4'b0000, 1, 0, 2'd0, 0, 0, 4'b0000, 0};
        vecs[8]  = '{4'b0101, 4'b0100, 1, 1, 2'd2, 1, 1, 4'b0100, 1};
        vecs[9]  = '{4'b0101, 4'b0000, 1, 0, 2'd0, 0, 0, 4'b0000, 1};
        vecs[10] = '{4'b0101, 4'b0000, 1, 0, 2'd0, 0, 0, 4'b0000, 1};
        vecs[11] = '{4'b0101, 4'b0000, 1, 0, 2'd0, 0, 0, 4'b0000, 0};
        vecs[12] = '{4'b0100, 4'b0000, 1, 0, 2'd0, 0, 0, 4'b0001, 1};
        vecs[13] = '{4'b0101, 4'b0001, 1, 1, 2'd0, 1, 1, 4'b0001, 1};
        vecs[14] = '{4'b0000, 4'b0000, 1, 0, 2'd0, 0, 0, 4'b0000, 1};
        vecs[15] = '{4'b0000, 4'b0000, 1, 0, 2'd0, 0, 0, 4'b0000, 1};
        vecs[16] = '{4'b0000, 4'b0000, 1, 0, 2'd0, 0, 0, 4'b0000, 0};
        exp2 = '{0, 2, 0, 2};
        exp3 = '{0, 1, 2, 3, 0};

        // Quiet after reset release
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            chk($sformatf("idle_c%0d", c), {busy, out_valid, req_ready}, 0);
        end

        // Vector table: single-byte-lane packets, stall, gap, rotation, bubble
        do_reset();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            req_valid = vecs[i].rv;
            req_last  = vecs[i].rl;
            out_ready = vecs[i].ordy;
            req_data  = 32'hD3C2B1A0;
            #1;
            expd = vecs[i].ev ? 8'hA0 + 8'h11 * 8'(vecs[i].evc) : 8'h00;
            chk($sformatf("vec%0d", i),
                {out_valid, out_vc, out_sop, out_eop, req_ready, busy, out_data, timeout},
                {vecs[i].ev, vecs[i].evc, vecs[i].es, vecs[i].ee,
                 vecs[i].erdy, vecs[i].eb, expd, 1'b0});
        end

        // Two sources alternate, fixed gap
        do_reset();
        run_stream(4'b0101, 1'b0, -1, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("alt_order%0d", i), ord(i), exp2[i]);
        chk("alt_gaps", gap_q.size(), 3);
        for (int i = 0; i < gap_q.size(); i++) begin
            chk($sformatf("alt_gap%0d", i), gap_q[i], 2);
            chk($sformatf("alt_idle%0d", i), idle_q[i], 1);
        end
        chk("alt_protocol", bad, 0);
        chk("alt_bubbles", bubs, 0);

        // All four sources with out_ready toggling
        do_reset();
        run_stream(4'b1111, 1'b1, -1, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), ord(i), exp3[i]);
        chk("rr_protocol", bad, 0);

        // Source 1 drops valid mid-packet while source 3 waits
        do_reset();
        run_stream(4'b1010, 1'b0, 1, 2);
        chk("bub_order0", ord(0), 1);
        chk("bub_order1", ord(1), 3);
        chk("bub_count", bubs, 3);
        chk("bub_protocol", bad, 0);

        // 12-byte packet against an 8-byte watchdog limit
        do_reset();
        k = 0; vis = 0; eop_at = 0; to_cnt = 0; to_at = 0; done = 0; bad = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            req_valid = (k < 12) ? 4'b0001 : 4'b0000;
            req_data  = '0;
            req_data[7:0] = 8'h40 + 8'(k);
            req_last  = {3'b000, k == 11};
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                vis++;
                if (out_data !== 8'h40 + 8'(k)) bad++;
                if (out_eop) eop_at = k + 1;
            end
            if (timeout) begin
                to_cnt++;
                to_at = k + 1;
            end
            if (req_valid[0] && req_ready[0]) k++;
            if (k == 12 && !busy) done = 1;
        end
        chk("wd_done", done, 1);
        chk("wd_consumed", k, 12);
        chk("wd_visible", vis, WD ? 8 : 12);
        chk("wd_eop_byte", eop_at, WD ? 8 : 12);
        chk("wd_timeouts", to_cnt, WD ? 1 : 0);
        chk("wd_timeout_byte", to_at, WD ? 8 : 0);
        chk("wd_data", bad, 0);

        // Reset asserted while byte 3 of a packet is on the output
        do_reset();
        i1 = 0; hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            req_valid = 4'b0010;
            req_data  = '0;
            req_data[15:8] = pkt_byte(1, i1);
            req_last  = {2'b00, i1 == 5, 1'b0};
            out_ready = 1'b1;
            #1;
            if (out_valid && i1 == 2) hit = 1;
            else if (req_valid[1] && req_ready[1]) i1++;
        end
        chk("rst_reach_byte3", hit, 1);
        reset = 1'b1;
        #1;
        chk("rst_outputs",
            {out_valid, out_sop, out_eop, out_data, out_vc, req_ready, busy, timeout}, 0);
        req_valid = 4'b0011;
        req_data  = '0;
        req_data[7:0]  = pkt_byte(0, 0);
        req_data[15:8] = pkt_byte(1, 0);
        req_last  = '0;
        @(negedge clk);
        reset = 1'b0;
        lat = -1; lvc = -1; lsop = -1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (out_valid && lat < 0) begin
                lat  = c;
                lvc  = int'(out_vc);
                lsop = int'(out_sop);
            end
            @(negedge clk);
        end
        chk("rst_latency", lat, 1);
        chk("rst_first_vc", lvc, 0);
        chk("rst_first_sop", lsop, 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
